// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Pure definitions: no logic, no latency, no backpressure.
package freq_div_pkg;

    localparam int CNT_W_DEF    = 27;
    localparam int DEF_HALF_DEF = 50_000_000;
    localparam int HALF_STOP    = 0;

    // Channel-index width; a single channel still needs a 1-bit select port.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: counter, shadow/active half-period, 50% clk_out and tick.
// Registered outputs, tick coincides with the clk_out toggle; no backpressure.
module freq_div_channel
    import freq_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_HALF = DEF_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [CNT_W-1:0] half,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_half;
    logic [CNT_W-1:0] shadow_half;
    logic             pend;
    logic             stopped;
    logic             term;

    assign stopped = (active_half == CNT_W'(HALF_STOP));
    // Only meaningful while running, so active_half-1 never wraps where it matters.
    assign term    = (cnt == active_half - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            active_half <= CNT_W'(DEF_HALF);
            shadow_half <= CNT_W'(DEF_HALF);
            pend        <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (stopped) begin
                cnt <= '0;
                if (we) begin
                    shadow_half <= half;
                    if (half != CNT_W'(HALF_STOP)) begin
                        active_half <= half;
                    end
                end
            end else if (en && term) begin
                // Period boundary: the only point where the half-period may change.
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
                pend    <= 1'b0;
                if (we) begin
                    active_half <= half;
                    shadow_half <= half;
                end else if (pend) begin
                    active_half <= shadow_half;
                end
            end else begin
                if (en) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (we) begin
                    shadow_half <= half;
                    pend        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/freq_div_multi.sv
// NUM_CH reprogrammable 50% dividers with tick strobes, plus a free-running scan counter.
// Outputs registered (1-cycle); config writes always accepted, out-of-range channel ignored.
module freq_div_multi
    import freq_div_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_HALF = DEF_HALF_DEF,
    parameter int SCAN_LSB = 15,
    parameter int SCAN_W   = 2,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [SCAN_W-1:0] scan_ctl
);

    localparam int SCAN_TOP = SCAN_LSB + SCAN_W;

    logic [SCAN_TOP-1:0] scan_cnt;

    // Scan counter deliberately ignores en so the display keeps refreshing.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_TOP'(1);
        end
    end

    assign scan_ctl = scan_cnt[SCAN_TOP-1:SCAN_LSB];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_we;

        // Equality against i < NUM_CH also rejects out-of-range indices.
        assign ch_we = cfg_we && (32'(cfg_ch) == i);

        freq_div_channel #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .we      (ch_we),
            .half    (cfg_half),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_freq_div_multi.sv
// Bench for freq_div_multi: directed scenarios plus random traffic against a countdown model.
module tb_freq_div_multi;

    localparam int NCH   = 2;
    localparam int CW    = 8;
    localparam int DHALF = 4;

    logic           clk;
    logic           rst;
    logic           en;
    logic           cfg_we;
    logic [0:0]     cfg_ch;
    logic [CW-1:0]  cfg_half;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [1:0]     scan_ctl;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remaining enabled edges until the next toggle.
    int       m_half   [NCH];
    int       m_shadow [NCH];
    int       m_rem    [NCH];
    bit       m_pend   [NCH];
    logic [NCH-1:0] m_out  = '0;
    logic [NCH-1:0] m_tick = '0;
    int       m_edges = 0;

    freq_div_multi #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .DEF_HALF (DHALF),
        .SCAN_LSB (2),
        .SCAN_W   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .clk_out  (clk_out),
        .tick     (tick),
        .scan_ctl (scan_ctl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic w, input int c, input int h);
        if (r) begin
            for (int k = 0; k < NCH; k++) begin
                m_half[k] = DHALF; m_shadow[k] = DHALF; m_rem[k] = DHALF; m_pend[k] = 0;
            end
            m_out = '0; m_tick = '0; m_edges = 0;
            return;
        end
        m_edges++;
        for (int k = 0; k < NCH; k++) begin
            bit wr;
            wr = w && (c == k);
            m_tick[k] = 1'b0;
            if (m_half[k] == 0) begin
                if (wr) begin
                    m_shadow[k] = h;
                    if (h != 0) begin m_half[k] = h; m_rem[k] = h; end
                end
            end else if (e) begin
                m_rem[k]--;
                if (m_rem[k] == 0) begin
                    m_out[k]  = ~m_out[k];
                    m_tick[k] = 1'b1;
                    if (wr) begin m_half[k] = h; m_shadow[k] = h; end
                    else if (m_pend[k]) m_half[k] = m_shadow[k];
                    m_pend[k] = 0;
                    m_rem[k]  = m_half[k];
                end else if (wr) begin
                    m_shadow[k] = h; m_pend[k] = 1;
                end
            end else if (wr) begin
                m_shadow[k] = h; m_pend[k] = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic w, input int c, input int h);
        rst      = r;
        en       = e;
        cfg_we   = w;
        cfg_ch   = 1'(c);
        cfg_half = CW'(h);
        @(posedge clk);
        model_step(r, e, w, c, h);
        #1;
        check("clk_out", 32'(clk_out), 32'(m_out));
        check("tick", 32'(tick), 32'(m_tick));
        check("scan_ctl", 32'(scan_ctl), 32'((m_edges >> 2) & 3));
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;

        // Reset state
        do_reset();
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_scan", 32'(scan_ctl), 0);

        // Free run at default half-period; scan wraps after 16 edges
        for (int e = 1; e <= 16; e++) begin
            step(0, 1, 0, 0, 0);
            if (e == 3)  check("run_tick3", 32'(tick), 0);
            if (e == 4)  check("run_tick4", 32'(tick), 3);
            if (e == 8)  check("run_clk8", 32'(clk_out), 0);
            if (e == 12) check("run_clk12", 32'(clk_out), 3);
            if (e == 4)  check("run_scan4", 32'(scan_ctl), 1);
            if (e == 16) check("run_scan16", 32'(scan_ctl), 0);
        end

        // Pending write on ch1 applies at its next boundary
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            step(0, 1, e == 2, 1, 2);
            if (e == 6) check("pend_tick6", 32'(tick), 2);
            if (e == 8) check("pend_tick8", 32'(tick), 3);
        end

        // Write coinciding with terminal count takes effect immediately
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            step(0, 1, e == 4, 0, 1);
            if (e >= 5) check("tc_wr_tick0", 32'(tick[0]), 1);
        end

        // Stop via zero, then restart
        do_reset();
        for (int e = 1; e <= 27; e++) begin
            step(0, 1, (e == 5) || (e == 20), 0, (e == 20) ? 3 : 0);
            if (e == 12) check("stop_tick12", 32'(tick[0]), 0);
            if (e == 23) check("restart_tick23", 32'(tick[0]), 1);
            if (e == 26) check("restart_tick26", 32'(tick[0]), 1);
        end

        // Enable gap delays the toggles but not the scan counter
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            step(0, !(e >= 2 && e <= 6), 0, 0, 0);
            if (e == 4) check("en_tick4", 32'(tick), 0);
            if (e == 9) check("en_tick9", 32'(tick), 3);
        end

        // Reset discards a pending write
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            step(e == 10, 1, e == 9, 1, 2);
            if (e == 10) begin
                check("mid_rst_clk", 32'(clk_out), 0);
                check("mid_rst_scan", 32'(scan_ctl), 0);
            end
        end
        for (int e = 1; e <= 8; e++) begin
            step(0, 1, 0, 0, 0);
            if (e == 4) check("post_rst_tick4", 32'(tick), 3);
        end

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic r, e, w;
            int c, h;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            w = ($urandom_range(0, 7) == 0);
            c = $urandom_range(0, NCH - 1);
            h = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6);
            step(r, e, w, c, h);
            if (r) check("rnd_rst_tick", 32'(tick), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
